// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch flushes,
// data-memory wait freezes, halt/drain/resume and a sticky memory-timeout trap.
module pipeline_ctrl #(
   parameter int MEM_TIMEOUT  = 16,
   parameter int DRAIN_CYCLES = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_uses_rs1,
   input  logic       id_uses_rs2,
   input  logic [4:0] ex_rd,
   input  logic       ex_memtoreg,
   input  logic       ex_reg_en,
   input  logic       ex_branch_taken,
   input  logic       mem_req,
   input  logic       mem_ready,
   input  logic       halt_req,
   input  logic       resume,
   output logic       pc_en,
   output logic       if_id_en,
   output logic       id_ex_en,
   output logic       ex_mem_en,
   output logic       mem_wb_en,
   output logic       if_id_flush,
   output logic       id_ex_flush,
   output logic       ex_mem_flush,
   output logic       mem_wb_flush,
   output logic [1:0] state,
   output logic       halted,
   output logic       mem_timeout
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      DRAIN    = 2'd2,
      HALTED   = 2'd3
   } state_t;

   localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
   localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
   localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);
   localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(MEM_TIMEOUT);
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

   // Bit positions inside en_vec / flush_vec
   localparam int PC = 4;
   localparam int IF_ID = 3;
   localparam int ID_EX = 2;
   localparam int EX_MEM = 1;
   localparam int MEM_WB = 0;

   state_t              state_reg;
   logic [WAIT_W-1:0]   wait_cnt_reg;
   logic [DRAIN_W-1:0]  drain_cnt_reg;
   logic                halted_reg;
   logic                mem_timeout_reg;

   logic                busy;
   logic                timeout_hit;
   logic                load_use;
   logic [4:0]          id_rs [2];
   logic [1:0]          id_uses;
   logic [1:0]          src_hit;
   logic [4:0]          en_vec;
   logic [3:0]          flush_vec;

   assign busy        = mem_req & ~mem_ready;
   assign timeout_hit = busy && (wait_cnt_reg == WAIT_LAST);

   assign id_rs[0]   = id_rs1;
   assign id_rs[1]   = id_rs2;
   assign id_uses[0] = id_uses_rs1;
   assign id_uses[1] = id_uses_rs2;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_src
         assign src_hit[gi] = id_uses[gi] & (id_rs[gi] == ex_rd);
      end
   endgenerate

   assign load_use = ex_memtoreg & ex_reg_en & (ex_rd != 5'd0) & (|src_hit);

   always_comb begin
      en_vec    = '1;
      flush_vec = '0;
      if (reset) begin
         en_vec    = '0;
         flush_vec = '1;
      end else begin
         case (state_reg)
            RUN, MEM_WAIT: begin
               if (busy) begin
                  en_vec = '0;
               end else if (ex_branch_taken) begin
                  flush_vec[IF_ID] = 1'b1;
                  flush_vec[ID_EX] = 1'b1;
                  en_vec[PC]       = ~halt_req;
               end else if (halt_req) begin
                  en_vec[PC]       = 1'b0;
                  flush_vec[IF_ID] = 1'b1;
               end else if (load_use) begin
                  en_vec[PC]       = 1'b0;
                  en_vec[IF_ID]    = 1'b0;
                  flush_vec[ID_EX] = 1'b1;
               end
            end
            DRAIN: begin
               if (busy) begin
                  en_vec = '0;
               end else begin
                  en_vec[PC]       = 1'b0;
                  flush_vec[IF_ID] = 1'b1;
               end
            end
            default: en_vec = '0;
         endcase
      end
   end

   assign pc_en        = en_vec[PC];
   assign if_id_en     = en_vec[IF_ID];
   assign id_ex_en     = en_vec[ID_EX];
   assign ex_mem_en    = en_vec[EX_MEM];
   assign mem_wb_en    = en_vec[MEM_WB];
   assign if_id_flush  = flush_vec[IF_ID];
   assign id_ex_flush  = flush_vec[ID_EX];
   assign ex_mem_flush = flush_vec[EX_MEM];
   assign mem_wb_flush = flush_vec[MEM_WB];

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg       <= RUN;
         wait_cnt_reg    <= '0;
         drain_cnt_reg   <= '0;
         halted_reg      <= 1'b0;
         mem_timeout_reg <= 1'b0;
      end else begin
         if (!busy)
            wait_cnt_reg <= '0;
         else if (wait_cnt_reg != WAIT_MAX)
            wait_cnt_reg <= wait_cnt_reg + 1'b1;

         if (timeout_hit) begin
            state_reg       <= HALTED;
            halted_reg      <= 1'b1;
            mem_timeout_reg <= 1'b1;
            drain_cnt_reg   <= '0;
         end else begin
            case (state_reg)
               RUN, MEM_WAIT: begin
                  // A halt request enters DRAIN whether or not a branch is also flushing.
                  if (busy) begin
                     state_reg <= MEM_WAIT;
                  end else if (halt_req) begin
                     state_reg     <= DRAIN;
                     drain_cnt_reg <= DRAIN_W'(1);
                  end else begin
                     state_reg <= RUN;
                  end
               end
               DRAIN: begin
                  if (!busy) begin
                     if (drain_cnt_reg == DRAIN_LAST) begin
                        state_reg     <= HALTED;
                        halted_reg    <= 1'b1;
                        drain_cnt_reg <= '0;
                     end else begin
                        drain_cnt_reg <= drain_cnt_reg + 1'b1;
                     end
                  end
               end
               default: begin
                  if (resume && !mem_timeout_reg) begin
                     state_reg  <= RUN;
                     halted_reg <= 1'b0;
                  end
               end
            endcase
         end
      end
   end

   assign state       = state_reg;
   assign halted      = halted_reg;
   assign mem_timeout = mem_timeout_reg;

endmodule
